sha256_round_ctrl: RTL and testbench

Sequencer for one SHA-256 compression.
- Accepts a 512-bit message block over a valid/ready handshake.
- Runs the 16-word message-schedule window.
- Drives the round index into the K-constant lookup and the W_t word into the compression datapath.
- Issues the init, round-enable and final-add strobes that step the working-variable datapath.
- Sits between the block feeder (header/nonce builder) and the compression datapath in the mining core.

---
 rtl/sha256_pkg.sv | 35 +++
 rtl/sha256_msg_sched.sv | 44 ++++
 rtl/sha256_round_ctrl.sv | 156 +++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and helpers for the compression sequencer and datapath.
//   word_t / block_t : 32-bit word and 512-bit message block
//   state_t          : round-controller FSM states
//   sig0 / sig1      : message-schedule small sigma functions
package sha256_pkg;

    localparam int unsigned SHA_ROUNDS = 64;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BLK_WORDS  = 16;

    typedef logic [WORD_W-1:0]           word_t;
    typedef logic [BLK_WORDS*WORD_W-1:0] block_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FINAL,
        DONE
    } state_t;

    // Rotate right by a constant amount (n in 1..31)
    function automatic word_t ror(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t sig0(input word_t x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sig1(input word_t x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule window: 16 words, loaded from a block, shifted down
// one word per round with the next expanded word appended at the top.
//   clk, rst : clock, synchronous active-high reset
//   load_i   : capture blk_i into the window (word 0 = blk_i[511:480])
//   blk_i    : message block
//   shift_i  : advance the window by one word
//   w0_o     : window[0], the current schedule word
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  block_t blk_i,
    input  logic   shift_i,
    output word_t  w0_o
);

    word_t win_q [BLK_WORDS];
    word_t expand_c;

    // W[t+16] from the current window contents
    assign expand_c = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BLK_WORDS); i++) begin
                win_q[i] <= '0;
            end
        end else if (load_i) begin
            for (int i = 0; i < int'(BLK_WORDS); i++) begin
                win_q[i] <= blk_i[(BLK_WORDS*WORD_W-1) - WORD_W*i -: WORD_W];
            end
        end else if (shift_i) begin
            for (int i = 0; i < int'(BLK_WORDS) - 1; i++) begin
                win_q[i] <= win_q[i+1];
            end
            win_q[BLK_WORDS-1] <= expand_c;
        end
    end

    assign w0_o = win_q[0];

endmodule

// File: rtl/sha256_round_ctrl.sv
// Sequencer for one SHA-256 compression: accepts a block, runs the message
// schedule and issues init / round_en / final_add / done strobes.
// Optional macro SHA_ROUND_CTRL_ABORT_EN adds input 'abort' (kills LOAD/ROUND).
//   clk, rst            : clock, synchronous active-high reset
//   blk_valid/blk_ready : block handshake (ready only in IDLE)
//   blk_data, blk_first : block payload and start-from-IV flag
//   iv_sel              : latched blk_first
//   init, round_en      : datapath load / per-round enable
//   round_idx, w_t      : round index for K lookup and schedule word W_t
//   final_add, done     : digest add pulse and digest-valid pulse
//   busy                : controller not in IDLE
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = SHA_ROUNDS,
    parameter int unsigned IDX_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [511:0]     blk_data,
    input  logic             blk_first,
`ifdef SHA_ROUND_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             iv_sel,
    output logic             init,
    output logic             round_en,
    output logic [IDX_W-1:0] round_idx,
    output logic [31:0]      w_t,
    output logic             final_add,
    output logic             done,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    state_t           state_q;
    logic             iv_sel_q;
    logic             init_q;
    logic             round_en_q;
    logic [IDX_W-1:0] round_idx_q;
    word_t            w_t_q;
    logic             final_q;
    logic             done_q;
    logic             busy_q;

    logic  accept_c;
    logic  abort_c;
    logic  shift_c;
    word_t sched_w0;

    assign blk_ready = (state_q == IDLE);
    assign accept_c  = blk_valid && blk_ready;

`ifdef SHA_ROUND_CTRL_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Window advances on every edge that presents a new W_t: leaving LOAD and
    // every round except the last.
    assign shift_c = (state_q == LOAD) ||
                     ((state_q == ROUND) && (round_idx_q != LAST_IDX));

    sha256_msg_sched u_sched (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept_c),
        .blk_i   (blk_data),
        .shift_i (shift_c),
        .w0_o    (sched_w0)
    );

    // Sequencer FSM with registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            iv_sel_q    <= 1'b0;
            init_q      <= 1'b0;
            round_en_q  <= 1'b0;
            round_idx_q <= '0;
            w_t_q       <= '0;
            final_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            init_q  <= 1'b0;
            final_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        state_q  <= LOAD;
                        iv_sel_q <= blk_first;
                        init_q   <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort_c) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q     <= ROUND;
                        round_en_q  <= 1'b1;
                        round_idx_q <= '0;
                        w_t_q       <= sched_w0;
                    end
                end
                ROUND: begin
                    if (abort_c) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        round_en_q  <= 1'b0;
                        round_idx_q <= '0;
                        w_t_q       <= '0;
                    end else if (round_idx_q == LAST_IDX) begin
                        state_q     <= FINAL;
                        round_en_q  <= 1'b0;
                        round_idx_q <= '0;
                        w_t_q       <= '0;
                        final_q     <= 1'b1;
                    end else begin
                        round_idx_q <= round_idx_q + IDX_W'(1);
                        w_t_q       <= sched_w0;
                    end
                end
                FINAL: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign iv_sel    = iv_sel_q;
    assign init      = init_q;
    assign round_en  = round_en_q;
    assign round_idx = round_idx_q;
    assign w_t       = w_t_q;
    assign final_add = final_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: random and "abc" blocks checked cycle by cycle
// against a reference schedule computed with the textbook W_t recurrence.
module tb_sha256_round_ctrl;

    localparam int R     = 64;
    localparam int IDX_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             blk_valid;
    logic             blk_ready;
    logic [511:0]     blk_data;
    logic             blk_first;
`ifdef SHA_ROUND_CTRL_ABORT_EN
    logic             abort;
`endif
    logic             iv_sel;
    logic             init;
    logic             round_en;
    logic [IDX_W-1:0] round_idx;
    logic [31:0]      w_t;
    logic             final_add;
    logic             done;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_w [64];

    always #5 clk = ~clk;

    sha256_round_ctrl #(.ROUNDS(R), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
`ifdef SHA_ROUND_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .iv_sel    (iv_sel),
        .init      (init),
        .round_en  (round_en),
        .round_idx (round_idx),
        .w_t       (w_t),
        .final_add (final_add),
        .done      (done),
        .busy      (busy)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] dbl;
        dbl = {x, x};
        return 32'(dbl >> n);
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Full 64-word message schedule, standard definition
    task automatic fill_ref(input logic [511:0] b);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".blk_ready"}, 32'(blk_ready), 32'd1);
        chk({tag, ".busy"},      32'(busy),      32'd0);
        chk({tag, ".init"},      32'(init),      32'd0);
        chk({tag, ".round_en"},  32'(round_en),  32'd0);
        chk({tag, ".round_idx"}, 32'(round_idx), 32'd0);
        chk({tag, ".w_t"},       w_t,            32'd0);
        chk({tag, ".final_add"}, 32'(final_add), 32'd0);
        chk({tag, ".done"},      32'(done),      32'd0);
    endtask

    task automatic quiet_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, ".done"},      32'(done),      32'd0);
            chk({tag, ".final_add"}, 32'(final_add), 32'd0);
        end
    endtask

    // One block: offer at the next negedge, then check every cycle to done.
    // garbage_k/rst_k/abort_k: cycle offset after accept at which to inject.
    task automatic run_block(input string tag, input logic [511:0] d, input logic first,
                             input bit hold_valid, input int garbage_k,
                             input int rst_k, input int abort_k, input bit abort_late);
        logic e_ren;
        fill_ref(d);
        @(negedge clk);
        blk_valid = 1'b1;
        blk_data  = d;
        blk_first = first;
        chk_idle({tag, ".pre"});
        @(posedge clk);
        for (int k = 1; k <= R + 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (!hold_valid) blk_valid = 1'b0;
                blk_data  = rand_block();
                blk_first = ~first;
            end
            e_ren = (k >= 2) && (k <= R + 1);
            chk({tag, ".blk_ready"}, 32'(blk_ready), 32'd0);
            chk({tag, ".busy"},      32'(busy),      32'd1);
            chk({tag, ".iv_sel"},    32'(iv_sel),    32'(first));
            chk({tag, ".init"},      32'(init),      32'(k == 1));
            chk({tag, ".round_en"},  32'(round_en),  32'(e_ren));
            chk({tag, ".round_idx"}, 32'(round_idx), e_ren ? 32'(k - 2) : 32'd0);
            chk({tag, ".w_t"},       w_t,            e_ren ? exp_w[k - 2] : 32'd0);
            chk({tag, ".final_add"}, 32'(final_add), 32'(k == R + 2));
            chk({tag, ".done"},      32'(done),      32'(k == R + 3));
            if (k == garbage_k) begin
                blk_valid = 1'b1;
                blk_data  = rand_block();
            end
            if (k == garbage_k + 1) blk_valid = hold_valid;
            if (k == rst_k) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk_idle({tag, ".rst"});
                chk({tag, ".rst.iv_sel"}, 32'(iv_sel), 32'd0);
                quiet_cycles({tag, ".post_rst"}, 30);
                return;
            end
`ifdef SHA_ROUND_CTRL_ABORT_EN
            if (k == abort_k) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk_idle({tag, ".abort"});
                quiet_cycles({tag, ".post_abort"}, 10);
                return;
            end
            if (abort_late && k == R + 2) abort = 1'b1;
            if (abort_late && k == R + 3) abort = 1'b0;
`endif
        end
    endtask

    initial begin
        logic [511:0] abc;
        rst       = 1'b1;
        blk_valid = 1'b0;
        blk_data  = '0;
        blk_first = 1'b0;
`ifdef SHA_ROUND_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_idle("reset");
        chk("reset.iv_sel", 32'(iv_sel), 32'd0);

        abc = {32'h61626380, 448'h0, 32'h00000018};
        run_block("abc", abc, 1'b1, 1'b0, -1, -1, -1, 1'b0);

        run_block("garbage", rand_block(), 1'b0, 1'b0, 32, -1, -1, 1'b0);

        run_block("b2b_a", rand_block(), 1'b1, 1'b1, -1, -1, -1, 1'b0);
        run_block("b2b_b", rand_block(), 1'b0, 1'b0, -1, -1, -1, 1'b0);

        run_block("rst40", rand_block(), 1'b1, 1'b0, -1, 42, -1, 1'b0);
        run_block("after_rst", rand_block(), 1'b0, 1'b0, -1, -1, -1, 1'b0);

`ifdef SHA_ROUND_CTRL_ABORT_EN
        run_block("abort10", rand_block(), 1'b1, 1'b0, -1, -1, 12, 1'b0);
        run_block("abort_done", rand_block(), 1'b0, 1'b0, -1, -1, -1, 1'b1);
        run_block("after_abort", rand_block(), 1'b1, 1'b0, -1, -1, -1, 1'b0);
`endif

        @(negedge clk);
        chk_idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
